// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO drain UART transmitter: word width,
// frame bit counts and the transmitter state encoding.
package fifo_uart_pkg;

  localparam int DATA_W     = 6;
  localparam int START_BITS = 1;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = START_BITS + DATA_W + STOP_BITS;

  // Bit index of the last data bit; ends the DATA state.
  localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_W - 1);

  // Transmitter states (3 bits).
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;

  // Plain constants of the same encoding for the state register.
  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_POP    = POP;
  localparam logic [2:0] ST_LOAD   = LOAD;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;

  // Clock cycles from the first START cycle through the last STOP cycle.
  function automatic int frame_cycles(input int clks_per_bit, input bit parity_en);
    return (FRAME_BITS + int'(parity_en)) * clks_per_bit;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Connection between the 6-bit FIFO read side and its UART drain stage.
// master: the FIFO (supplies flag and data, receives pop).
// slave:  the drain stage (consumes flag and data, issues pop).
interface fifo_uart_tx_if;
  import fifo_uart_pkg::*;

  logic              fifo_empty_n;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_pop;

  modport master (
    output fifo_empty_n,
    output fifo_data,
    input  fifo_pop
  );

  modport slave (
    input  fifo_empty_n,
    input  fifo_data,
    output fifo_pop
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. clear holds the count at 0 so a bit starts aligned.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick = (cnt_q == LAST_CNT);

  // Next count: hold at zero while cleared, wrap on the terminal count.
  always_comb begin
    // NOTE: assign every always_comb output on every path (default first)
    // so no latch is inferred.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here: it is sampled on the clock edge like
    // any other input, so it only acts while clk is running.
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of block ordering.
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one 6-bit word whenever the FIFO is non-empty and
// transmission is enabled, then sends it as start, 6 data bits LSB first,
// optional even parity, stop. tx, fifo_pop and busy are all registered.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_en,
  fifo_uart_tx_if.slave        fifo,
  output logic                 tx,
  output logic                 busy
);

  logic [2:0]        state_q,   state_d;
  logic [DATA_W-1:0] shift_q,   shift_d;
  logic              parity_q,  parity_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              tx_q,      tx_d;
  logic              pop_q,     pop_d;
  logic              busy_q,    busy_d;

  logic baud_clear;
  logic baud_tick;

  // Bit timer only runs while a frame is on the line; it sits at zero in
  // IDLE/POP/LOAD so START always gets a full bit period.
  assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_POP) ||
                      (state_q == ST_LOAD);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (baud_clear),
    .tick    (baud_tick)
  );

  // Sequencing: next state, shift register, parity and bit counter.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // tx_en and the empty flag only matter here; a frame in flight
        // ignores both.
        if (tx_en && fifo.fifo_empty_n) begin
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // The FIFO presents the popped word one cycle after the pop strobe.
        shift_d   = fifo.fifo_data;
        parity_d  = ^fifo.fifo_data;
        bit_cnt_d = '0;
        state_d   = ST_START;
      end
      ST_START: begin
        if (baud_tick) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          if (bit_cnt_q == LAST_DATA_BIT) begin
            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the pins come straight off flops
  // and change only on bit boundaries.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
    pop_d  = (state_d == ST_POP);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any word already popped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      pop_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      pop_q     <= pop_d;
      busy_q    <= busy_d;
    end
  end

  assign tx            = tx_q;
  assign busy          = busy_q;
  assign fifo.fifo_pop = pop_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / even parity), each fed
// by a small registered-output FIFO model. Frames are checked against
// hand-computed bit sequences.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk;
  logic reset_n_a, reset_n_b;
  logic tx_en_a, tx_en_b;
  logic tx_a, tx_b;
  logic busy_a, busy_b;

  fifo_uart_tx_if if_a ();
  fifo_uart_tx_if if_b ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut_a (
    .clk     (clk),
    .reset_n (reset_n_a),
    .tx_en   (tx_en_a),
    .fifo    (if_a.slave),
    .tx      (tx_a),
    .busy    (busy_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut_b (
    .clk     (clk),
    .reset_n (reset_n_b),
    .tx_en   (tx_en_b),
    .fifo    (if_b.slave),
    .tx      (tx_b),
    .busy    (busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- FIFO models ----------------
  logic [5:0] mem_a [32];
  logic [5:0] mem_b [32];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  int pop_cnt_a = 0, pop_cnt_b = 0;
  int under_a = 0, under_b = 0;
  int cyc = 0;
  int pop_times_a [$];

  assign if_a.fifo_empty_n = (wr_a != rd_a);
  assign if_b.fifo_empty_n = (wr_b != rd_b);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (if_a.fifo_pop === 1'b1) begin
      pop_cnt_a <= pop_cnt_a + 1;
      pop_times_a.push_back(cyc);
      if (wr_a == rd_a) under_a <= under_a + 1;
      else begin
        if_a.fifo_data <= mem_a[rd_a % 32];
        rd_a <= rd_a + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (if_b.fifo_pop === 1'b1) begin
      pop_cnt_b <= pop_cnt_b + 1;
      if (wr_b == rd_b) under_b <= under_b + 1;
      else begin
        if_b.fifo_data <= mem_b[rd_b % 32];
        rd_b <= rd_b + 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit sel, input logic [5:0] w);
    if (sel) begin
      mem_b[wr_b % 32] = w;
      wr_b = wr_b + 1;
    end else begin
      mem_a[wr_a % 32] = w;
      wr_a = wr_a + 1;
    end
  endtask

  function automatic logic tx_of(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  function automatic logic pop_of(input bit sel);
    return sel ? if_b.fifo_pop : if_a.fifo_pop;
  endfunction

  // Waits (bounded) for the start bit, then checks every cycle of every bit
  // against exp (bit i = i-th bit on the line) and busy=1, then busy=0 and
  // tx=1 on the cycle after the stop bit. drop_bit >= 0 lowers tx_en at the
  // start of that bit.
  task automatic run_frame(input bit sel, input logic [8:0] exp, input int nbits,
                           input string name, input int drop_bit);
    int  bad;
    bit  found;
    found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (tx_of(sel) === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_start_seen"}, 32'(found), 32'd1);
    if (!found) return;
    for (int i = 0; i < nbits; i++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (!(i == 0 && c == 0)) @(negedge clk);
        if (i == drop_bit && c == 0) begin
          if (sel) tx_en_b = 1'b0;
          else     tx_en_a = 1'b0;
        end
        if (tx_of(sel) !== exp[i]) bad++;
        if (busy_of(sel) !== 1'b1) bad++;
      end
      check($sformatf("%s_bit%0d_bad_cycles", name, i), 32'(bad), 32'd0);
    end
    @(negedge clk);
    check({name, "_busy_after"}, 32'(busy_of(sel)), 32'd0);
    check({name, "_tx_after"},   32'(tx_of(sel)),   32'd1);
  endtask

  // Releases reset at the current negedge; the pop must appear on the 2nd
  // cycle after release and last one cycle.
  task automatic release_and_check(input bit sel, input string name);
    if (sel) reset_n_b = 1'b1;
    else     reset_n_a = 1'b1;
    check({name, "_pop_c1"}, 32'(pop_of(sel)), 32'd0);
    @(negedge clk);
    check({name, "_pop_c2"}, 32'(pop_of(sel)), 32'd1);
    @(negedge clk);
    check({name, "_pop_c3"}, 32'(pop_of(sel)), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         sel;
    logic [5:0] word;
    logic [8:0] bits;
    int         nbits;
    string      name;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int bad;
    int base;
    int pc;
    bit found;

    // Line bit sequences, bit 0 = start bit.
    vecs[0] = '{1'b1, 6'h07, 9'b110001110, 9, "par_07"};
    vecs[1] = '{1'b1, 6'h3F, 9'b101111110, 9, "par_3f"};
    vecs[2] = '{1'b0, 6'h15, 9'b010101010, 8, "np_15"};
    vecs[3] = '{1'b0, 6'h3E, 9'b011111100, 8, "np_3e"};

    // ---- reset then idle ----
    reset_n_a = 1'b0;
    reset_n_b = 1'b0;
    tx_en_a   = 1'b1;
    tx_en_b   = 1'b1;
    push(1'b0, 6'h2D);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      check($sformatf("rst%0d_tx", r),   32'(tx_a),          32'd1);
      check($sformatf("rst%0d_pop", r),  32'(if_a.fifo_pop), 32'd0);
      check($sformatf("rst%0d_busy", r), 32'(busy_a),        32'd0);
    end
    reset_n_b = 1'b1;
    release_and_check(1'b0, "rel0");
    run_frame(1'b0, 9'b011011010, 8, "w2d", -1);
    check("w2d_pop_count", 32'(pop_cnt_a), 32'd1);

    // ---- table-driven single frames ----
    for (int v = 0; v < 4; v++) begin
      push(vecs[v].sel, vecs[v].word);
      run_frame(vecs[v].sel, vecs[v].bits, vecs[v].nbits, vecs[v].name, -1);
    end
    check("par_pop_count", 32'(pop_cnt_b), 32'd2);
    check("b_idle_busy",   32'(busy_b),    32'd0);

    // ---- back-to-back: 0x01, 0x3E, 0x15 ----
    base = pop_times_a.size();
    push(1'b0, 6'h01);
    push(1'b0, 6'h3E);
    push(1'b0, 6'h15);
    run_frame(1'b0, 9'b010000010, 8, "b2b_01", -1);
    run_frame(1'b0, 9'b011111100, 8, "b2b_3e", -1);
    run_frame(1'b0, 9'b010101010, 8, "b2b_15", -1);
    check("b2b_pops", 32'(pop_times_a.size() - base), 32'd3);
    if (pop_times_a.size() - base == 3) begin
      check("b2b_gap1", 32'(pop_times_a[base+1] - pop_times_a[base]),   32'd35);
      check("b2b_gap2", 32'(pop_times_a[base+2] - pop_times_a[base+1]), 32'd35);
    end

    // ---- tx_en gating ----
    pc = pop_cnt_a;
    tx_en_a = 1'b0;
    push(1'b0, 6'h2A);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if_a.fifo_pop !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    check("en_off_bad_cycles", 32'(bad), 32'd0);
    check("en_off_pops", 32'(pop_cnt_a - pc), 32'd0);

    // Enable, then drop tx_en mid-frame; a second word stays queued.
    tx_en_a = 1'b1;
    push(1'b0, 6'h08);
    run_frame(1'b0, 9'b011010100, 8, "en_drop_2a", 2);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if_a.fifo_pop !== 1'b0 || tx_a !== 1'b1) bad++;
    end
    check("en_drop_quiet_bad", 32'(bad), 32'd0);
    check("en_drop_pops", 32'(pop_cnt_a - pc), 32'd1);

    // ---- reset mid-DATA (bit 3 of 0x08, which is the only 1) ----
    pc = pop_cnt_a;
    tx_en_a = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (tx_a === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_start_seen", 32'(found), 32'd1);
    repeat (17) @(negedge clk);
    check("mid_bit3_tx",   32'(tx_a),   32'd1);
    check("mid_bit3_busy", 32'(busy_a), 32'd1);
    push(1'b0, 6'h33);
    reset_n_a = 1'b0;
    @(negedge clk);
    check("mid_rst_tx",   32'(tx_a),   32'd1);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (if_a.fifo_pop !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    check("mid_rst_hold_bad", 32'(bad), 32'd0);
    check("mid_rst_pops", 32'(pop_cnt_a - pc), 32'd1);
    release_and_check(1'b0, "rel1");
    run_frame(1'b0, 9'b011100110, 8, "after_rst_33", -1);
    check("after_rst_pops", 32'(pop_cnt_a - pc), 32'd2);

    // ---- final bookkeeping ----
    check("a_underflow", 32'(under_a), 32'd0);
    check("b_underflow", 32'(under_b), 32'd0);
    check("a_drained",   32'(wr_a - rd_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
